credit_bp_tx_arb: RTL and testbench

CREDIT_BP_TX_ARB -- requirements
Module: credit_bp_tx_arb

---
 rtl/common_pkg.sv | 12 +
 rtl/noc_if.sv | 13 +
 rtl/credit_rr_arb.sv | 34 +++
 rtl/credit_bp_tx_arb.sv | 74 +++++++
 tb/tb_credit_bp_tx_arb.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/common_pkg.sv
// common_pkg: shared NoC defaults and the flit layout used by the VC transmitter
package common_pkg;
    localparam int DEFAULT_VC_W          = 2;
    localparam int DEFAULT_D_W           = 8;
    localparam int DEFAULT_A_W           = 4;
    localparam int DEFAULT_VC_FIFO_DEPTH = 4;
    typedef struct packed {
        logic                   last;
        logic [DEFAULT_A_W-1:0] addr;
        logic [DEFAULT_D_W-1:0] data;
    } flit_t;
endpackage

// File: rtl/noc_if.sv
// noc_if: credit-based link between a VC transmitter and its receiver
interface noc_if
    import common_pkg::*;
#(
    parameter int VC_W  = DEFAULT_VC_W,
    parameter int PKT_W = DEFAULT_A_W + DEFAULT_D_W + 1
);
    logic [VC_W-1:0]  credit_vc_target;
    logic [PKT_W-1:0] credit_packet;
    logic [VC_W-1:0]  credit_vc_credit_gnt;
    modport transmitter(output credit_vc_target, output credit_packet, input credit_vc_credit_gnt);
    modport receiver(input credit_vc_target, input credit_packet, output credit_vc_credit_gnt);
endinterface

// File: rtl/credit_rr_arb.sv
// credit_rr_arb: round-robin one-hot arbiter, priority starts after the last winner
module credit_rr_arb #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
    if (N == 1) begin : g_one
        assign gnt = req;
    end else begin : g_rr
        localparam int PW = $clog2(N);
        logic [PW-1:0] ptr_q, ptr_d, idx;
        // scan from lowest to highest priority so the last hit wins
        always_comb begin
            gnt   = '0;
            ptr_d = ptr_q;
            idx   = '0;
            for (int i = N; i >= 1; i--) begin
                idx = PW'((int'(ptr_q) + i) % N);
                if (req[idx]) begin
                    gnt      = '0;
                    gnt[idx] = 1'b1;
                    ptr_d    = idx;
                end
            end
        end
        always_ff @(posedge clk) begin
            if (rst) ptr_q <= PW'(N - 1);
            else     ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/credit_bp_tx_arb.sv
// credit_bp_tx_arb: per-VC credit counters, round-robin send arbitration and backpressure
module credit_bp_tx_arb
    import common_pkg::*;
#(
    parameter int VC_W         = DEFAULT_VC_W,
    parameter int D_W          = DEFAULT_D_W,
    parameter int A_W          = DEFAULT_A_W,
    parameter int DEPTH        = DEFAULT_VC_FIFO_DEPTH,
    parameter int INIT_CREDITS = DEPTH - 1,
    parameter int CNT_W        = $clog2(INIT_CREDITS + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [VC_W-1:0]                 i_v,
    input  logic [VC_W-1:0][A_W+D_W:0]      i_d,
    output logic [VC_W-1:0]                 o_b,
    noc_if.transmitter                      to_rx,
    output logic [VC_W-1:0][CNT_W-1:0]      o_credits,
    output logic [VC_W-1:0]                 o_err
);
    localparam int FW = A_W + D_W + 1;
    localparam logic [CNT_W-1:0] INIT = CNT_W'(INIT_CREDITS);
    logic [VC_W-1:0][CNT_W-1:0] credits_q, credits_d;
    logic [VC_W-1:0] err_q, err_d, target_q, target_d, has_credit, grant, gnt_in;
    logic [FW-1:0] packet_q, packet_d;
    assign gnt_in = to_rx.credit_vc_credit_gnt;
    always_comb begin
        for (int v = 0; v < VC_W; v++) has_credit[v] = credits_q[v] != '0;
    end
    credit_rr_arb #(.N(VC_W)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (i_v & has_credit),
        .gnt (grant)
    );
    assign o_b = ~has_credit | (i_v & ~grant);
    // grant is one-hot0, so OR-ing the selected flits is the payload mux
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        target_d  = grant;
        packet_d  = (|grant) ? '0 : packet_q;
        for (int v = 0; v < VC_W; v++) begin
            if (grant[v]) packet_d = packet_d | i_d[v];
            if (grant[v] && !gnt_in[v]) credits_d[v] = credits_q[v] - 1'b1;
            else if (gnt_in[v] && !grant[v]) begin
                if (credits_q[v] == INIT) err_d[v] = 1'b1;
                else credits_d[v] = credits_q[v] + 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            credits_q <= {VC_W{INIT}};
            err_q     <= '0;
            target_q  <= '0;
            packet_q  <= '0;
        end else begin
            credits_q <= credits_d;
            err_q     <= err_d;
            target_q  <= target_d;
            packet_q  <= packet_d;
        end
    end
    assign to_rx.credit_vc_target = target_q;
    assign to_rx.credit_packet    = packet_q;
    assign o_credits              = credits_q;
    assign o_err                  = err_q;
`ifdef SIMULATION
    a_target_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(target_q));
    a_target_sent: assert property (@(posedge clk) disable iff (rst) (target_q & ~$past(grant)) == '0);
    a_no_x: assert property (@(posedge clk) disable iff (rst) !$isunknown({i_v, o_b, target_q}));
`endif
endmodule

// File: tb/tb_credit_bp_tx_arb.sv
// tb_credit_bp_tx_arb: scenario tasks plus a scoreboard on the registered send outputs
module tb_credit_bp_tx_arb;
    localparam int FW = 13;
    typedef struct packed {
        logic [1:0]    t;
        logic [FW-1:0] p;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] i_v = '0, gnt = '0, o_b, o_err;
    logic [1:0][FW-1:0] i_d = '0;
    logic [1:0][1:0] o_credits;
    int errors = 0, checks = 0;
    exp_t q[$];
    exp_t got;
    logic [1:0][1:0] m_cred;
    int m_ptr;
    logic [FW-1:0] m_pkt;

    noc_if #(.VC_W(2), .PKT_W(FW)) bus ();
    assign bus.credit_vc_credit_gnt = gnt;

    credit_bp_tx_arb #(.VC_W(2), .D_W(8), .A_W(4), .DEPTH(4), .INIT_CREDITS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_v       (i_v),
        .i_d       (i_d),
        .o_b       (o_b),
        .to_rx     (bus),
        .o_credits (o_credits),
        .o_err     (o_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            got = q.pop_front();
            checks++;
            if (bus.credit_vc_target !== got.t || bus.credit_packet !== got.p) begin
                errors++;
                $display("FAIL sb_send target=%b pkt=%h expected target=%b pkt=%h",
                         bus.credit_vc_target, bus.credit_packet, got.t, got.p);
            end
        end
    end

    // predicts the send for the current inputs, queues it, then advances one cycle
    task automatic tick();
        logic [1:0] g;
        exp_t e;
        g = '0;
        for (int v = 0; v < 2; v++) i_d[v] = FW'($urandom);
        if (rst) begin
            m_cred = {2'd3, 2'd3};
            m_ptr  = 1;
            m_pkt  = '0;
        end else begin
            for (int k = 1; k <= 2; k++)
                if (g == 2'b00 && i_v[(m_ptr + k) % 2] && m_cred[(m_ptr + k) % 2] != 2'd0)
                    g[(m_ptr + k) % 2] = 1'b1;
            for (int v = 0; v < 2; v++) begin
                if (g[v]) begin
                    m_pkt = i_d[v];
                    m_ptr = v;
                end
                if (g[v] && !gnt[v]) m_cred[v] = m_cred[v] - 2'd1;
                else if (gnt[v] && !g[v] && m_cred[v] != 2'd3) m_cred[v] = m_cred[v] + 2'd1;
            end
        end
        e.t = g;
        e.p = m_pkt;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; i_v = '0; gnt = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if (o_credits !== 4'b1111) begin errors++; $display("FAIL reset_credits got=%h exp=f", o_credits); end
        checks++; if (o_b !== 2'b00) begin errors++; $display("FAIL reset_ob got=%b exp=00", o_b); end
        checks++; if (o_err !== 2'b00) begin errors++; $display("FAIL reset_err got=%b exp=00", o_err); end
        checks++; if (bus.credit_vc_target !== 2'b00) begin errors++; $display("FAIL reset_target got=%b exp=00", bus.credit_vc_target); end
    endtask

    task automatic test_single_vc();
        i_v = 2'b01; gnt = '0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (o_credits[0] !== 2'(3 - c)) begin errors++; $display("FAIL single_credits c=%0d got=%0d exp=%0d", c, o_credits[0], 3 - c); end
            checks++; if (o_b[0] !== (c == 3)) begin errors++; $display("FAIL single_ob c=%0d got=%b exp=%b", c, o_b[0], c == 3); end
            tick();
        end
        checks++; if (bus.credit_vc_target !== 2'b00) begin errors++; $display("FAIL single_no4th got=%b exp=00", bus.credit_vc_target); end
        checks++; if (o_credits[0] !== 2'd0) begin errors++; $display("FAIL single_empty got=%0d exp=0", o_credits[0]); end
        i_v = '0; gnt = 2'b01;
        tick(); tick(); tick();
        gnt = '0;
        checks++; if (o_credits !== 4'b1111) begin errors++; $display("FAIL single_refill got=%h exp=f", o_credits); end
        checks++; if (o_err !== 2'b00) begin errors++; $display("FAIL single_err got=%b exp=00", o_err); end
    endtask

    task automatic test_alternate();
        i_v = 2'b11;
        for (int k = 0; k < 6; k++) begin
            gnt = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
            #1;
            checks++; if (o_b !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL alt_ob k=%0d got=%b", k, o_b); end
            tick();
            checks++; if (bus.credit_vc_target !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL alt_target k=%0d got=%b", k, bus.credit_vc_target); end
        end
        i_v = '0; gnt = 2'b10;
        tick();
        gnt = '0;
        checks++; if (o_credits !== 4'b1111) begin errors++; $display("FAIL alt_credits got=%h exp=f", o_credits); end
    endtask

    task automatic test_same_cycle();
        i_v = 2'b10; gnt = '0;
        tick(); tick();
        checks++; if (o_credits[1] !== 2'd1) begin errors++; $display("FAIL same_setup got=%0d exp=1", o_credits[1]); end
        gnt = 2'b10;
        tick();
        checks++; if (o_credits[1] !== 2'd1) begin errors++; $display("FAIL same_credits got=%0d exp=1", o_credits[1]); end
        checks++; if (bus.credit_vc_target !== 2'b10) begin errors++; $display("FAIL same_target got=%b exp=10", bus.credit_vc_target); end
        i_v = '0;
        tick(); tick();
        gnt = '0;
        checks++; if (o_credits !== 4'b1111) begin errors++; $display("FAIL same_refill got=%h exp=f", o_credits); end
    endtask

    task automatic test_overflow();
        i_v = '0; gnt = 2'b01;
        tick();
        gnt = '0;
        checks++; if (o_credits[0] !== 2'd3) begin errors++; $display("FAIL ovf_credits got=%0d exp=3", o_credits[0]); end
        checks++; if (o_err !== 2'b01) begin errors++; $display("FAIL ovf_err got=%b exp=01", o_err); end
        tick(); tick(); tick();
        checks++; if (o_err !== 2'b01) begin errors++; $display("FAIL ovf_sticky got=%b exp=01", o_err); end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (o_err !== 2'b00) begin errors++; $display("FAIL mid_errclr got=%b exp=00", o_err); end
        i_v = 2'b11;
        for (int k = 0; k < 3; k++) begin
            gnt = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
            tick();
        end
        rst = 1'b1; gnt = 2'b01;
        tick();
        rst = 1'b0; gnt = '0;
        checks++; if (bus.credit_vc_target !== 2'b00) begin errors++; $display("FAIL mid_target got=%b exp=00", bus.credit_vc_target); end
        checks++; if (o_credits !== 4'b1111) begin errors++; $display("FAIL mid_credits got=%h exp=f", o_credits); end
        tick();
        checks++; if (bus.credit_vc_target !== 2'b01) begin errors++; $display("FAIL mid_first got=%b exp=01", bus.credit_vc_target); end
        i_v = '0; gnt = 2'b01;
        tick();
        gnt = '0;
        checks++; if (o_credits !== 4'b1111) begin errors++; $display("FAIL mid_refill got=%h exp=f", o_credits); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_vc();
        test_reset();
        test_alternate();
        test_same_cycle();
        test_overflow();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
